// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, byte width and baud divisor helper.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Clocks per bit; also used by uart_fifo_tx so both ends share the same divisor.
   function automatic int baud_cnt_max(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and registered full/empty flags.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       wr_en_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic                       rd_en_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rd_data_q;
   logic              full_q, empty_q;
   logic              do_push, do_pop;

   assign do_push = wr_en_i && !full_q;
   assign do_pop  = rd_en_i && !empty_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; only pointers, count and flags are cleared.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            rd_data_q <= mem_q[rd_ptr_q];
         end
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign rd_data_o = rd_data_q;
   assign empty_o   = empty_q;
   assign full_o    = full_q;
   assign count_o   = count_q;

endmodule

// File: rtl/uart_fifo_rx.sv
// UART 8N1 receiver feeding a sync_fifo; framing/overflow errors reported as 1-cycle pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_fifo_rx
   import uart_pkg::*;
#(
   parameter int UART_BSP   = 115200,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [DATA_W-1:0]             data_out,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   data_count,
   output logic                          frame_err,
   output logic                          overflow
`ifdef UART_RX_PARITY_EN
   ,
   output logic                          parity_err
`endif
);

   localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BSP);
   localparam int BAUD_HALF    = BAUD_CNT_MAX / 2;
   localparam int CNT_W        = $clog2(BAUD_CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_HALF - 1);

   logic              rx_meta_q, rx_s_q, rx_d_q;
   uart_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_idx_q;
   logic [DATA_W-1:0] shift_q;
   logic              cnt_last, stop_hit, par_bad, push_req, fifo_full;

`ifdef UART_RX_PARITY_EN
   logic par_q;
   assign par_bad = ^{shift_q, par_q};
`else
   assign par_bad = 1'b0;
`endif

   assign cnt_last  = (cnt_q == CNT_LAST);
   assign stop_hit  = (state_q == STOP) && cnt_last;
   assign push_req  = stop_hit && rx_s_q && !par_bad;
   assign frame_err = stop_hit && !rx_s_q;
   assign overflow  = push_req && fifo_full;
`ifdef UART_RX_PARITY_EN
   assign parity_err = stop_hit && rx_s_q && par_bad;
`endif

   // Sync chain resets high so a reset release never looks like a start edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_d_q    <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_d_q    <= rx_s_q;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (rx_d_q && !rx_s_q) state_q <= START;
            end
            START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rx_s_q ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt_last) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_s_q, shift_q[DATA_W-1:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_last) begin
                  cnt_q   <= '0;
                  par_q   <= rx_s_q;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               // Leave at mid stop bit so the next start edge is never missed.
               if (cnt_last) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (sys_clk),
      .rst_n_i   (sys_rst_n),
      .wr_en_i   (push_req),
      .wr_data_i (shift_q),
      .rd_en_i   (rd_en),
      .rd_data_o (data_out),
      .empty_o   (empty),
      .full_o    (fifo_full),
      .count_o   (data_count)
   );

   assign full = fifo_full;

endmodule

// File: tb/tb_uart_fifo_rx.sv
// Scoreboard bench for uart_fifo_rx; runs at 32 clocks per bit to keep the run short.
module tb_uart_fifo_rx;

   localparam int CLK_FREQ = 50_000_000;
   localparam int UART_BSP = 1_562_500;
   localparam int DEPTH    = 16;
   localparam int BIT      = CLK_FREQ / UART_BSP;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] data_out;
   logic       empty, full, frame_err, overflow;
   logic [4:0] data_count;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   uart_fifo_rx #(
      .UART_BSP   (UART_BSP),
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .rx         (rx),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .empty      (empty),
      .full       (full),
      .data_count (data_count),
      .frame_err  (frame_err),
      .overflow   (overflow)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #10 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc = 0;
   int ferr_cnt = 0, ovf_cnt = 0, perr_cnt = 0;
   int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
   int fall_cyc = -1;
   int last_start = 0;
   int mcount = 0;
   logic empty_prev = 1'b1;
   logic [7:0] exp_q[$];

   always @(negedge sys_clk) begin
      cyc++;
      if (sys_rst_n) begin
         if (frame_err === 1'b1) ferr_cnt++;
         if (overflow === 1'b1) ovf_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err === 1'b1) perr_cnt++;
`endif
         if (empty_prev && empty === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
      end
      empty_prev = empty;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
      @(negedge sys_clk);
      rx = 1'b0;
      last_start = cyc;
      repeat (BIT) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT) @(negedge sys_clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^d) ^ par_flip;
      repeat (BIT) @(negedge sys_clk);
`endif
      rx = stop_b;
      repeat (BIT) @(negedge sys_clk);
      rx = 1'b1;
      if (!stop_b) exp_ferr++;
`ifdef UART_RX_PARITY_EN
      else if (par_flip) exp_perr++;
`endif
      else if (mcount < DEPTH) begin
         exp_q.push_back(d);
         mcount++;
      end else exp_ovf++;
   endtask

   task automatic pop_expect(input string tag);
      logic [7:0] e;
      @(negedge sys_clk);
      rd_en = 1'b1;
      @(negedge sys_clk);
      rd_en = 1'b0;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         mcount--;
         check_eq(tag, {24'd0, data_out}, {24'd0, e});
      end
   endtask

   initial begin
      repeat (5) @(negedge sys_clk);
      check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
      check_eq("rst_empty", {31'd0, empty}, 32'd1);
      check_eq("rst_full", {31'd0, full}, 32'd0);
      check_eq("rst_count", {27'd0, data_count}, 32'd0);
      check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
      sys_rst_n = 1'b1;
      repeat (10) @(negedge sys_clk);

      // single byte and latency to empty falling
      fall_cyc = -1;
      send_frame(8'h41, 1'b1, 1'b0);
      check_eq("lat_9p5_bits", {31'd0, (fall_cyc - last_start >= BIT*9 + BIT/2 - 8) &&
                                       (fall_cyc - last_start <= BIT*9 + BIT/2 + 8)}, 32'd1);
      check_eq("count_one", {27'd0, data_count}, 32'd1);
      pop_expect("pop_41");
      check_eq("empty_after_pop", {31'd0, empty}, 32'd1);

      // back-to-back bytes
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0);
      check_eq("count_three", {27'd0, data_count}, 32'd3);
      for (int i = 0; i < 3; i++) pop_expect("pop_b2b");
      check_eq("b2b_no_ferr", ferr_cnt, exp_ferr);

      // low stop bit, then a held-low break
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (BIT) @(negedge sys_clk);
      check_eq("ferr_once", ferr_cnt, exp_ferr);
      check_eq("ferr_no_push", {27'd0, data_count}, 32'd0);
      @(negedge sys_clk);
      rx = 1'b0;
      repeat (BIT*30) @(negedge sys_clk);
      rx = 1'b1;
      exp_ferr++;
      repeat (BIT*2) @(negedge sys_clk);
      check_eq("break_one_ferr", ferr_cnt, exp_ferr);
      check_eq("break_no_push", {27'd0, data_count}, 32'd0);

      // fill past capacity
      for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
      check_eq("full_at_16", {31'd0, full}, 32'd1);
      send_frame(8'h11, 1'b1, 1'b0);
      repeat (4) @(negedge sys_clk);
      check_eq("overflow_pulse", ovf_cnt, exp_ovf);
      check_eq("count_16", {27'd0, data_count}, 32'd16);
      for (int i = 0; i < 16; i++) pop_expect("pop_fill");
      check_eq("empty_after_drain", {31'd0, empty}, 32'd1);
      @(negedge sys_clk);
      rd_en = 1'b1;
      @(negedge sys_clk);
      rd_en = 1'b0;
      check_eq("rd_empty_holds", {24'd0, data_out}, 32'h10);
      check_eq("rd_empty_count", {27'd0, data_count}, 32'd0);

      // start glitch
      @(negedge sys_clk);
      rx = 1'b0;
      repeat (BIT/4) @(negedge sys_clk);
      rx = 1'b1;
      repeat (BIT*12) @(negedge sys_clk);
      check_eq("glitch_no_ferr", ferr_cnt, exp_ferr);
      check_eq("glitch_no_push", {31'd0, empty}, 32'd1);

      // reset during bit 4 of a frame, with a byte already buffered
      send_frame(8'h77, 1'b1, 1'b0);
      @(negedge sys_clk);
      rx = 1'b0;
      repeat (BIT) @(negedge sys_clk);
      for (int i = 0; i < 4; i++) begin
         rx = ((8'h3C >> i) & 8'h01) != 0;
         repeat (BIT) @(negedge sys_clk);
      end
      rx = 1'b1;
      repeat (BIT/2) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_eq("mid_rst_data_out", {24'd0, data_out}, 32'd0);
      check_eq("mid_rst_empty", {31'd0, empty}, 32'd1);
      check_eq("mid_rst_full", {31'd0, full}, 32'd0);
      check_eq("mid_rst_count", {27'd0, data_count}, 32'd0);
      check_eq("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
      exp_q.delete();
      mcount = 0;
      repeat (BIT) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (BIT*2) @(negedge sys_clk);
      send_frame(8'h3C, 1'b1, 1'b0);
      pop_expect("pop_3c");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h03, 1'b1, 1'b1);
      repeat (4) @(negedge sys_clk);
      check_eq("parity_err_pulse", perr_cnt, exp_perr);
      check_eq("parity_no_push", {27'd0, data_count}, 32'd0);
`endif

      check_eq("total_ferr", ferr_cnt, exp_ferr);
      check_eq("total_ovf", ovf_cnt, exp_ovf);
      check_eq("total_perr", perr_cnt, exp_perr);
      check_eq("sb_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
